// File: rtl/w5300_bus_arbiter.sv
`default_nettype none
// ============================================================================
// w5300_bus_arbiter : round-robin owner of the W5300 bus engine, whole-transaction grants
// Rev 1.0
// ============================================================================
module w5300_bus_arbiter #(
   parameter int         NUM_CLIENTS    = 4,
   parameter logic [9:0] IDLE_ADDR      = 10'h3fe,
   parameter int         TIMEOUT_CYCLES = 4096
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_CLIENTS-1:0]    req,
   input  logic [NUM_CLIENTS*10-1:0] cl_addr,
   input  logic [NUM_CLIENTS*16-1:0] cl_wr_data,
   output logic [NUM_CLIENTS-1:0]    gnt,
   output logic [NUM_CLIENTS-1:0]    cl_op_state,
   output logic [9:0]                bus_addr,
   output logic [15:0]               bus_wr_data,
   output logic                      bus_valid,
   input  logic                      op_state,
   input  logic                      bus_busy,
   output logic                      err_timeout
);

   localparam int PTR_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
   localparam int WD_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_GRANT = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   logic [1:0]             state_q, state_d;
   logic [PTR_W-1:0]       ptr_q, ptr_d;
   logic [PTR_W-1:0]       sel_q, sel_d;
   logic [NUM_CLIENTS-1:0] gnt_q, gnt_d;
   logic [NUM_CLIENTS-1:0] blk_q, blk_d;
   logic [WD_W-1:0]        wd_q, wd_d;

   logic [NUM_CLIENTS-1:0] eligible;
   logic                   win_found;
   logic [PTR_W-1:0]       win_idx;
   logic                   wd_hit;

   // A client revoked by the watchdog stays blocked until its req is seen low.
   assign eligible = req & ~blk_q;

   // Descending scan so the smallest offset from ptr is the last (winning) write.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
         if (eligible[(int'(ptr_q) + k) % NUM_CLIENTS]) begin
            win_found = 1'b1;
            win_idx   = PTR_W'((int'(ptr_q) + k) % NUM_CLIENTS);
         end
      end
   end

   generate
      if (TIMEOUT_CYCLES > 0) begin : g_wd
         assign wd_hit = (state_q == S_GRANT) && req[sel_q] && !op_state &&
                         (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
      end else begin : g_no_wd
         assign wd_hit = 1'b0;
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      sel_d   = sel_q;
      gnt_d   = gnt_q;
      wd_d    = wd_q;
      blk_d   = blk_q & req;
      case (state_q)
         S_IDLE: begin
            if (win_found) begin
               state_d = S_GRANT;
               sel_d   = win_idx;
               gnt_d   = NUM_CLIENTS'(1) << win_idx;
               ptr_d   = PTR_W'((int'(win_idx) + 1) % NUM_CLIENTS);
               wd_d    = '0;
            end
         end
         S_GRANT: begin
            if (!req[sel_q] || wd_hit) begin
               gnt_d   = '0;
               state_d = bus_busy ? S_DRAIN : S_IDLE;
               if (wd_hit) begin
                  blk_d[sel_q] = 1'b1;
               end
            end else if (op_state) begin
               wd_d = '0;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end
         S_DRAIN: begin
            if (!bus_busy) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         sel_q   <= '0;
         gnt_q   <= '0;
         blk_q   <= '0;
         wd_q    <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         sel_q   <= sel_d;
         gnt_q   <= gnt_d;
         blk_q   <= blk_d;
         wd_q    <= wd_d;
      end
   end

   // In Drain the mux keeps the last owner so the in-flight access word is stable.
   always_comb begin
      bus_addr    = IDLE_ADDR;
      bus_wr_data = '0;
      if (state_q != S_IDLE) begin
         bus_addr    = cl_addr[int'(sel_q) * 10 +: 10];
         bus_wr_data = cl_wr_data[int'(sel_q) * 16 +: 16];
      end
   end

   assign bus_valid   = (state_q == S_GRANT);
   assign gnt         = gnt_q;
   assign cl_op_state = gnt_q & {NUM_CLIENTS{op_state & bus_valid}};
   assign err_timeout = wd_hit;

endmodule
`default_nettype wire

// File: tb/tb_w5300_bus_arbiter.sv
`default_nettype none
// ============================================================================
// tb_w5300_bus_arbiter : randomized bench against a transaction-level owner model
// Rev 1.0
// ============================================================================
module tb_w5300_bus_arbiter;

   localparam int         NC   = 4;
   localparam int         TMO  = 16;
   localparam logic [9:0] IDLE = 10'h3fe;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [NC-1:0] req;
   logic [NC*10-1:0] cl_addr;
   logic [NC*16-1:0] cl_wr_data;
   logic [NC-1:0] gnt, cl_op_state;
   logic [9:0]    bus_addr;
   logic [15:0]   bus_wr_data;
   logic          bus_valid, op_state, bus_busy, err_timeout;

   w5300_bus_arbiter #(
      .NUM_CLIENTS(NC), .IDLE_ADDR(IDLE), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .cl_addr(cl_addr), .cl_wr_data(cl_wr_data),
      .gnt(gnt), .cl_op_state(cl_op_state), .bus_addr(bus_addr), .bus_wr_data(bus_wr_data),
      .bus_valid(bus_valid), .op_state(op_state), .bus_busy(bus_busy), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   int n_to_seen = 0;

   // Reference model: who owns the bus, whether it is draining, next search start.
   int      m_owner;
   bit      m_drain;
   int      m_rr;
   int      m_wd;
   bit [NC-1:0] m_blk;

   int left [NC];
   int drv_mode;
   bit rand_mode;
   int stall;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_owner = -1;
      m_drain = 0;
      m_rr    = 0;
      m_wd    = 0;
      m_blk   = '0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_gnt"},   32'(gnt), 32'd0);
      check({tag, "_valid"}, 32'(bus_valid), 32'd0);
      check({tag, "_addr"},  32'(bus_addr), 32'(IDLE));
      check({tag, "_wdat"},  32'(bus_wr_data), 32'd0);
      check({tag, "_clop"},  32'(cl_op_state), 32'd0);
      check({tag, "_err"},   32'(err_timeout), 32'd0);
   endtask

   // Check outputs at the negedge, then advance the model across the next posedge.
   task automatic step();
      logic [NC-1:0] e_gnt, e_cl, nb;
      logic [9:0]    e_addr;
      logic [15:0]   e_wdat;
      logic          e_valid, e_err;
      @(negedge clk);
      e_valid = (m_owner >= 0) && !m_drain;
      e_gnt   = '0;
      e_addr  = IDLE;
      e_wdat  = '0;
      e_err   = 1'b0;
      if (m_owner >= 0) begin
         e_addr = cl_addr[m_owner*10 +: 10];
         e_wdat = cl_wr_data[m_owner*16 +: 16];
         if (e_valid) begin
            e_gnt[m_owner] = 1'b1;
            e_err = req[m_owner] && !op_state && (m_wd == TMO - 1);
         end
      end
      e_cl = (e_valid && op_state) ? e_gnt : '0;
      check("gnt", 32'(gnt), 32'(e_gnt));
      check("bus_valid", 32'(bus_valid), 32'(e_valid));
      check("bus_addr", 32'(bus_addr), 32'(e_addr));
      check("bus_wr_data", 32'(bus_wr_data), 32'(e_wdat));
      check("cl_op_state", 32'(cl_op_state), 32'(e_cl));
      check("err_timeout", 32'(err_timeout), 32'(e_err));
      if (err_timeout === 1'b1) n_to_seen++;

      nb = m_blk & req;
      if (m_owner < 0) begin
         for (int k = 0; k < NC; k++) begin
            int c;
            c = (m_rr + k) % NC;
            if (m_owner < 0 && req[c] && !m_blk[c]) begin
               m_owner = c;
               m_drain = 0;
               m_wd    = 0;
               m_rr    = (c + 1) % NC;
            end
         end
      end else if (!m_drain) begin
         if (!req[m_owner] || e_err) begin
            if (e_err) nb[m_owner] = 1'b1;
            if (bus_busy) m_drain = 1;
            else m_owner = -1;
         end else begin
            m_wd = op_state ? 0 : m_wd + 1;
         end
      end else if (!bus_busy) begin
         m_owner = -1;
         m_drain = 0;
      end
      m_blk = nb;
      for (int i = 0; i < NC; i++) if (e_cl[i]) left[i]--;
      @(posedge clk);
      #1;
   endtask

   // Client and bus-driver behaviour for the next cycle.
   task automatic drive();
      for (int i = 0; i < NC; i++) begin
         cl_addr[i*10 +: 10]    = 10'($urandom);
         cl_wr_data[i*16 +: 16] = 16'($urandom);
         if (req[i]) begin
            if (left[i] <= 0) req[i] = 1'b0;
            else if (rand_mode && m_blk[i] && ($urandom % 4 == 0)) req[i] = 1'b0;
            else if (rand_mode && ($urandom % 64 == 0)) req[i] = 1'b0;
         end else if (rand_mode && ($urandom % 4 == 0)) begin
            req[i]  = 1'b1;
            left[i] = 1 + int'($urandom % 4);
         end
      end
      case (drv_mode)
         0: begin
            if (stall == 0 && ($urandom % 150 == 0)) stall = 20 + int'($urandom % 10);
            if (stall > 0) begin
               stall--;
               op_state = 1'b0;
               bus_busy = 1'b1;
            end else begin
               op_state = ($urandom % 3 == 0);
               bus_busy = ($urandom % 2 == 0);
            end
         end
         1: begin
            op_state = ~op_state;
            bus_busy = 1'b0;
         end
         default: begin
            op_state = 1'b0;
            bus_busy = 1'b0;
         end
      endcase
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         step();
         drive();
      end
   endtask

   task automatic run_to_idle(input string tag);
      int c;
      c = 0;
      while (m_owner >= 0 && c < 300) begin
         step();
         drive();
         c++;
      end
      check(tag, 32'(m_owner < 0), 32'd1);
   endtask

   initial begin
      rst_n = 1'b0; req = '0; cl_addr = '0; cl_wr_data = '0;
      op_state = 1'b0; bus_busy = 1'b0;
      drv_mode = 1; rand_mode = 0; stall = 0;
      for (int i = 0; i < NC; i++) left[i] = 0;
      model_reset();
      #3;
      check_reset_outputs("reset");
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      run(9);

      // Single client, three accesses
      req[2] = 1'b1; left[2] = 3;
      run(1);
      check("single_gnt", 32'(gnt), 32'h4);
      run_to_idle("single_idle");
      check("single_done", 32'(left[2]), 32'd0);

      // ptr now 3: client 3 wins over client 0, then client 0
      req = 4'b1001; left[0] = 1; left[3] = 1;
      run(1);
      check("wrap_first", 32'(gnt), 32'h8);
      run(10);
      run_to_idle("wrap_idle");

      // Watchdog: both clients stuck, neither re-granted until req toggles
      drv_mode = 2;
      req = 4'b0110; left[1] = 99; left[2] = 99;
      run(60);
      check("wd_pulses", 32'(n_to_seen), 32'd2);
      check("wd_stuck", 32'(gnt), 32'h0);
      req[1] = 1'b0;
      run(1);
      req[1] = 1'b1;
      run(1);
      check("wd_regrant", 32'(gnt), 32'h2);
      req = '0;
      drv_mode = 1;
      run(2);
      run_to_idle("wd_idle");

      // Reset in the middle of a grant
      req[1] = 1'b1; left[1] = 50;
      run(4);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      model_reset();
      req = '0;
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      req = 4'b1111;
      for (int i = 0; i < NC; i++) left[i] = 1;
      run(1);
      check("rst_first", 32'(gnt), 32'h1);
      run(20);

      // Randomized traffic
      drv_mode = 0; rand_mode = 1;
      run(3000);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
